// File: rtl/s7_pkg.sv
// Shared definitions for the seven-segment display path: converter FSM
// encodings and elaboration-time sizing helpers.
package s7_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        SHIFT = ST_SHIFT_ENC,
        DONE  = ST_DONE_ENC
    } state_t;

    // Largest value representable with the given number of decimal digits.
    function automatic logic [63:0] max_dec_value(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    function automatic int cnt_width(input int bin_width);
        return $clog2(bin_width + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] digit_adj
);

    assign digit_adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding s7_display.
// Build option: BCD_OVERFLOW_SATURATE_EN forces all-9 digits on overflow.
module bin2bcd_seq
    import s7_pkg::*;
#(
    parameter int DISPLAYS_NUM = 4,
    parameter int BIN_WIDTH    = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [BIN_WIDTH-1:0]      i_bin,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
    output logic                      o_valid,
    output logic                      o_overflow
);

    localparam int              BCD_W        = DISPLAYS_NUM * 4;
    localparam int              CNT_W        = cnt_width(BIN_WIDTH);
    localparam logic [63:0]     MAX_DEC      = max_dec_value(DISPLAYS_NUM);
    localparam logic [63:0]     BIN_MAX      = (64'd1 << BIN_WIDTH) - 64'd1;
    localparam bit              OVF_POSSIBLE = (BIN_MAX > MAX_DEC);
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(BIN_WIDTH);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0]     bcd_sr;
    logic [BCD_W-1:0]     bcd_adj;
    logic                 ovf_lat;
    logic                 ovf_cmp;
    logic                 accept;

`ifdef BCD_OVERFLOW_SATURATE_EN
    function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] v,
                                                 input logic ovf);
        return ovf ? {DISPLAYS_NUM{4'h9}} : v;
    endfunction
`endif

    // Narrow widths can never exceed the display range; keep the flag at 0.
    generate
        if (OVF_POSSIBLE) begin : g_ovf
            assign ovf_cmp = (64'(i_bin) > MAX_DEC);
        end else begin : g_no_ovf
            assign ovf_cmp = 1'b0;
        end
    endgenerate

    for (genvar d = 0; d < DISPLAYS_NUM; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit     (bcd_sr[4*d +: 4]),
            .digit_adj (bcd_adj[4*d +: 4])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                o_ready   = 1'b1;
                state_nxt = i_valid ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = o_ready && i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= '0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            ovf_lat    <= 1'b0;
            o_bcd_data <= '0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state == SHIFT) begin
                // The top scratch bit falls off, leaving value mod 10^DISPLAYS_NUM.
                bcd_sr <= BCD_W'({bcd_adj, bin_sr[BIN_WIDTH-1]});
                bin_sr <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
                cnt    <= cnt - CNT_W'(1);
            end
            if (state == DONE) begin
`ifdef BCD_OVERFLOW_SATURATE_EN
                o_bcd_data <= sat_bcd(bcd_sr, ovf_lat);
`else
                o_bcd_data <= bcd_sr;
`endif
                o_overflow <= ovf_lat;
                o_valid    <= 1'b1;
            end
            if (accept) begin
                bin_sr  <= i_bin;
                bcd_sr  <= '0;
                ovf_lat <= ovf_cmp;
                cnt     <= CNT_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;

    localparam int DISPLAYS_NUM = 4;
    localparam int BIN_WIDTH    = 14;
    localparam int BCD_W        = DISPLAYS_NUM * 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [BIN_WIDTH-1:0] i_bin;
    logic                 i_valid;
    logic                 o_ready;
    logic [BCD_W-1:0]     o_bcd_data;
    logic                 o_valid;
    logic                 o_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(
        .DISPLAYS_NUM (DISPLAYS_NUM),
        .BIN_WIDTH    (BIN_WIDTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_bin      (i_bin),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_bcd_data (o_bcd_data),
        .o_valid    (o_valid),
        .o_overflow (o_overflow)
    );

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic model_ovf(input longint v);
        return v > pow10(DISPLAYS_NUM) - 1;
    endfunction

    function automatic logic [BCD_W-1:0] model_bcd(input longint v);
        logic [BCD_W-1:0] r;
        longint m;
        r = '0;
`ifdef BCD_OVERFLOW_SATURATE_EN
        if (model_ovf(v)) begin
            for (int i = 0; i < DISPLAYS_NUM; i++) r[4*i +: 4] = 4'h9;
            return r;
        end
`endif
        m = v % pow10(DISPLAYS_NUM);
        for (int i = 0; i < DISPLAYS_NUM; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Single conversion from an idle DUT; called at a falling edge.
    task automatic convert(input logic [BIN_WIDTH-1:0] v, input string name);
        logic [BCD_W-1:0] prev;
        logic [BCD_W-1:0] exp_bcd;
        int               low;
        bit               seen;
        bit               changed;
        prev    = o_bcd_data;
        exp_bcd = model_bcd(longint'(v));
        low     = 0;
        seen    = 1'b0;
        changed = 1'b0;
        i_bin   = v;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (o_valid) begin
                seen = 1'b1;
            end else begin
                if (!o_ready) low++;
                if (o_bcd_data !== prev) changed = 1'b1;
                @(negedge clk);
            end
        end
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s timeout: o_valid seen=%0d required 1", name, seen);
        end
        tests_run++;
        if (o_bcd_data !== exp_bcd) begin
            tests_failed++;
            $display("FAIL %s bcd: got %h required %h (bin %0d)", name, o_bcd_data, exp_bcd, v);
        end
        tests_run++;
        if (o_overflow !== model_ovf(longint'(v))) begin
            tests_failed++;
            $display("FAIL %s overflow: got %b required %b", name, o_overflow, model_ovf(longint'(v)));
        end
        tests_run++;
        if (low != BIN_WIDTH) begin
            tests_failed++;
            $display("FAIL %s ready_low: got %0d cycles required %0d", name, low, BIN_WIDTH);
        end
        tests_run++;
        if (changed) begin
            tests_failed++;
            $display("FAIL %s hold: output changed before o_valid, required stable %h", name, prev);
        end
        @(negedge clk);
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s pulse_width: o_valid got %b required 0 one cycle later", name, o_valid);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_bin   = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_bcd_data !== '0 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: bcd=%h valid=%b ovf=%b ready=%b required 0000/0/0/1",
                     o_bcd_data, o_valid, o_overflow, o_ready);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: ready=%b valid=%b required 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_single();
        convert(14'd1234, "conv_1234");
    endtask

    task automatic test_boundaries();
        convert(14'd9999,  "conv_9999");
        convert(14'd0,     "conv_zero");
        convert(14'd10000, "conv_10000");
        convert(14'd16383, "conv_16383");
    endtask

    task automatic test_back_to_back();
        logic [BIN_WIDTH-1:0] vals[$];
        logic [BIN_WIDTH-1:0] exp_q[$];
        logic [BIN_WIDTH-1:0] e;
        int idx, got, cyc, last_cyc, n;
        vals.push_back(14'd5);
        vals.push_back(14'd42);
        vals.push_back(14'd777);
        for (int i = 0; i < 3; i++) vals.push_back(BIN_WIDTH'($urandom_range(0, 16383)));
        n = vals.size();
        idx = 0; got = 0; cyc = 0; last_cyc = -1;
        while (got < n && cyc < 300) begin
            if (o_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_extra: unexpected result %h required none", o_bcd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_bcd_data !== model_bcd(longint'(e)) || o_overflow !== model_ovf(longint'(e))) begin
                        tests_failed++;
                        $display("FAIL b2b_data[%0d]: got %h/%b required %h/%b", got, o_bcd_data,
                                 o_overflow, model_bcd(longint'(e)), model_ovf(longint'(e)));
                    end
                end
                if (last_cyc >= 0) begin
                    tests_run++;
                    if (cyc - last_cyc != BIN_WIDTH + 1) begin
                        tests_failed++;
                        $display("FAIL b2b_period[%0d]: got %0d cycles required %0d", got,
                                 cyc - last_cyc, BIN_WIDTH + 1);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (o_ready) begin
                if (idx < n) begin
                    i_bin   = vals[idx];
                    i_valid = 1'b1;
                    exp_q.push_back(vals[idx]);
                    idx++;
                end else begin
                    i_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        i_valid = 1'b0;
        tests_run++;
        if (got != n) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results required %0d", got, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int pulses;
        convert(14'd1234, "abort_pre");
        i_bin   = 14'd4321;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (o_bcd_data !== '0 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: bcd=%h ready=%b valid=%b ovf=%b required 0000/1/0/0",
                     o_bcd_data, o_ready, o_valid, o_overflow);
        end
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (o_valid) pulses++;
            @(negedge clk);
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL abort_no_valid: got %0d pulses required 0", pulses);
        end
        convert(14'd4321, "abort_post");
    endtask

    task automatic test_ignore_busy();
        logic [BIN_WIDTH-1:0] a, b;
        logic [BCD_W-1:0]     res[2];
        int got;
        a = BIN_WIDTH'($urandom_range(0, 9999));
        b = BIN_WIDTH'((int'(a) + 1 + $urandom_range(0, 5000)) % 10000);
        got = 0;
        i_bin   = a;
        i_valid = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        i_bin = b;
        for (int k = 0; k < 80 && got < 2; k++) begin
            if (o_valid) begin
                res[got] = o_bcd_data;
                got++;
                i_valid = 1'b0;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        tests_run++;
        if (got != 2) begin
            tests_failed++;
            $display("FAIL busy_count: got %0d results required 2", got);
        end else begin
            tests_run++;
            if (res[0] !== model_bcd(longint'(a))) begin
                tests_failed++;
                $display("FAIL busy_inflight: got %h required %h", res[0], model_bcd(longint'(a)));
            end
            tests_run++;
            if (res[1] !== model_bcd(longint'(b))) begin
                tests_failed++;
                $display("FAIL busy_next: got %h required %h", res[1], model_bcd(longint'(b)));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            convert(BIN_WIDTH'($urandom_range(0, 16383)), "conv_random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_back_to_back();
        test_reset_abort();
        test_ignore_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
